// File: rtl/instr_encoder_if.sv
// Request/response bus for instr_encoder: operation requests in, encoded words out.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_kind;
    logic [3:0]        req_aluop;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [31:0]       req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport slave (
        input  req_valid, req_kind, req_aluop, req_rd, req_rs1, req_rs2, req_imm, out_ready,
        output req_ready, out_valid, out_instr, out_addr
    );

    modport master (
        output req_valid, req_kind, req_aluop, req_rd, req_rs1, req_rs2, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs abstract operation requests into 32-bit instruction words, buffers them
// in a 2-entry FIFO and streams them out with an incrementing word address.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clear,
    instr_encoder_if.slave      bus,
    output logic                o_err_illegal,
    output logic [7:0]          o_err_count
);
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 2;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [INSTR_W-1:0] r_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_err_illegal;
    logic [7:0]         r_err_count;

    logic [INSTR_W-1:0] w_word;
    logic               w_legal;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic [11:0]        w_imm12;
    logic               w_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_unused;

    // Upper immediate bits are never part of any format.
    assign w_unused = &{1'b0, bus.req_imm[31:21]};

    assign w_ready  = (r_count != CNT_W'(2));
    assign w_accept = bus.req_valid && w_ready;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = (r_count != '0) && bus.out_ready;

    assign bus.req_ready = w_ready;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_instr = r_mem[r_rd_ptr];
    assign bus.out_addr  = r_addr;
    assign o_err_illegal = r_err_illegal;
    assign o_err_count   = r_err_count;

    // Combinational encoder: selects format and function fields from kind/aluop.
    always_comb begin
        w_legal = 1'b1;
        w_word  = '0;
        w_f3    = '0;
        w_f7    = '0;
        w_imm12 = '0;
        case (bus.req_kind)
            3'd0: begin
                case (bus.req_aluop)
                    4'b0000: begin w_f3 = 3'b000; w_f7 = 7'b0000000; end
                    4'b0001: begin w_f3 = 3'b000; w_f7 = 7'b0100000; end
                    4'b0010: begin w_f3 = 3'b000; w_f7 = 7'b0000001; end
                    4'b0011: begin w_f3 = 3'b000; w_f7 = 7'b0000010; end
                    4'b1111: begin w_f3 = 3'b011; w_f7 = 7'b0000011; end
                    4'b1011: begin w_f3 = 3'b001; w_f7 = 7'b0000000; end
                    4'b1100: begin w_f3 = 3'b101; w_f7 = 7'b0000000; end
                    4'b1110: begin w_f3 = 3'b101; w_f7 = 7'b0100000; end
                    4'b0100: begin w_f3 = 3'b111; w_f7 = 7'b0000000; end
                    4'b1000: begin w_f3 = 3'b111; w_f7 = 7'b0100000; end
                    4'b0101: begin w_f3 = 3'b110; w_f7 = 7'b0000000; end
                    4'b1001: begin w_f3 = 3'b110; w_f7 = 7'b0100000; end
                    4'b0110: begin w_f3 = 3'b100; w_f7 = 7'b0000000; end
                    4'b1010: begin w_f3 = 3'b100; w_f7 = 7'b0100000; end
                    4'b1101: begin w_f3 = 3'b010; w_f7 = 7'b0000001; end
                    default: w_legal = 1'b0;
                endcase
                w_word = {w_f7, bus.req_rs2, bus.req_rs1, w_f3, bus.req_rd, OP_R};
            end
            3'd1: begin
                case (bus.req_aluop)
                    4'b0000: begin w_f3 = 3'b000; w_imm12 = bus.req_imm[11:0]; end
                    4'b0101: begin w_f3 = 3'b110; w_imm12 = bus.req_imm[11:0]; end
                    4'b0110: begin w_f3 = 3'b100; w_imm12 = bus.req_imm[11:0]; end
                    4'b1100: begin w_f3 = 3'b101; w_imm12 = {7'b0000000, bus.req_imm[4:0]}; end
                    4'b1011: begin w_f3 = 3'b101; w_imm12 = {7'b0000001, bus.req_imm[4:0]}; end
                    default: w_legal = 1'b0;
                endcase
                w_word = {w_imm12, bus.req_rs1, w_f3, bus.req_rd, OP_I};
            end
            3'd2: w_word = {bus.req_imm[11:0], bus.req_rs1, 3'b010, bus.req_rd, OP_LOAD};
            3'd3: w_word = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, 3'b010,
                            bus.req_imm[4:0], OP_STORE};
            3'd4: w_word = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1,
                            {2'b00, bus.req_aluop[0]}, bus.req_imm[4:1], bus.req_imm[11],
                            OP_BRANCH};
            3'd5: w_word = {bus.req_imm[20], bus.req_imm[10:1], bus.req_imm[11],
                            bus.req_imm[19:12], bus.req_rd, OP_JAL};
            default: w_legal = 1'b0;
        endcase
    end

    // FIFO storage, pointers, occupancy and head address; reset and clear flush everything.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
            r_addr   <= ADDR_W'(BASE_ADDR);
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_addr   <= r_addr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky illegal flag and saturating drop counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_err_illegal <= 1'b0;
            r_err_count   <= '0;
        end else if (w_accept && !w_legal) begin
            r_err_illegal <= 1'b1;
            if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan steps plus random
// traffic, checked every cycle against a queue-based reference model.
module tb_instr_encoder;
    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       err_illegal;
    logic [7:0] err_count;
    logic       rst2_n;
    logic       clear2;
    logic       err2_illegal;
    logic [7:0] err2_count;

    int compared   = 0;
    int mismatched = 0;

    instr_encoder_if #(.ADDR_W(8)) bus ();
    instr_encoder_if #(.ADDR_W(2)) bus2 ();

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .bus(bus),
        .o_err_illegal(err_illegal), .o_err_count(err_count)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst2_n), .i_clear(clear2), .bus(bus2),
        .o_err_illegal(err2_illegal), .o_err_count(err2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] q[$];
    int          exp_addr;
    bit          exp_err;
    int          exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Encoding rules written as field arithmetic from the instruction tables.
    function automatic void ref_encode(input int kind, input int op, input bit [31:0] rd,
                                       input bit [31:0] rs1, input bit [31:0] rs2,
                                       input bit [31:0] imm, output bit legal,
                                       output logic [31:0] w);
        bit [31:0] f3, f7, ims;
        legal = 1'b1; f3 = 0; f7 = 0; ims = 0; w = 0;
        case (kind)
            0: begin
                case (op)
                    0:  begin f3 = 0; f7 = 0;  end
                    1:  begin f3 = 0; f7 = 32; end
                    2:  begin f3 = 0; f7 = 1;  end
                    3:  begin f3 = 0; f7 = 2;  end
                    15: begin f3 = 3; f7 = 3;  end
                    11: begin f3 = 1; f7 = 0;  end
                    12: begin f3 = 5; f7 = 0;  end
                    14: begin f3 = 5; f7 = 32; end
                    4:  begin f3 = 7; f7 = 0;  end
                    8:  begin f3 = 7; f7 = 32; end
                    5:  begin f3 = 6; f7 = 0;  end
                    9:  begin f3 = 6; f7 = 32; end
                    6:  begin f3 = 4; f7 = 0;  end
                    10: begin f3 = 4; f7 = 32; end
                    13: begin f3 = 2; f7 = 1;  end
                    default: legal = 1'b0;
                endcase
                w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            end
            1: begin
                case (op)
                    0:  begin f3 = 0; ims = imm & 32'hFFF; end
                    5:  begin f3 = 6; ims = imm & 32'hFFF; end
                    6:  begin f3 = 4; ims = imm & 32'hFFF; end
                    12: begin f3 = 5; ims = imm & 32'h1F; end
                    11: begin f3 = 5; ims = (imm & 32'h1F) + 32; end
                    default: legal = 1'b0;
                endcase
                w = (ims << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            end
            2: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
            3: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                   | ((imm & 32'h1F) << 7) | 32'h23;
            4: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
                   | (rs1 << 15) | ((op & 1) << 12) | (((imm >> 1) & 15) << 8)
                   | (((imm >> 11) & 1) << 7) | 32'h63;
            5: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12)
                   | (rd << 7) | 32'h6F;
            default: legal = 1'b0;
        endcase
    endfunction

    // Check all outputs against the model, then advance model and DUT one clock.
    task automatic cycle();
        bit          legal;
        logic [31:0] w;
        bit          pop, acc;
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("req_ready", 32'(bus.req_ready), 32'(q.size() != 2));
        if (q.size() != 0) chk("out_instr", bus.out_instr, q[0]);
        chk("out_addr", 32'(bus.out_addr), 32'(exp_addr));
        chk("err_illegal", 32'(err_illegal), 32'(exp_err));
        chk("err_count", 32'(err_count), 32'(exp_cnt));
        if (!rst_n || clear) begin
            q.delete();
            exp_addr = 0;
            exp_err  = 1'b0;
            exp_cnt  = 0;
        end else begin
            pop = (q.size() != 0) && bus.out_ready;
            acc = bus.req_valid && (q.size() != 2);
            ref_encode(int'(bus.req_kind), int'(bus.req_aluop), 32'(bus.req_rd),
                       32'(bus.req_rs1), 32'(bus.req_rs2), bus.req_imm, legal, w);
            if (pop) begin
                void'(q.pop_front());
                exp_addr = (exp_addr + 1) % 256;
            end
            if (acc && legal) q.push_back(w);
            if (acc && !legal) begin
                exp_err = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int kind, input int op, input int rd, input int rs1,
                           input int rs2, input logic [31:0] imm);
        bus.req_kind  = 3'(kind);
        bus.req_aluop = 4'(op);
        bus.req_rd    = 5'(rd);
        bus.req_rs1   = 5'(rs1);
        bus.req_rs2   = 5'(rs2);
        bus.req_imm   = imm;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; rst2_n = 1'b0; clear2 = 1'b0;
        bus.req_valid = 1'b0; bus.out_ready = 1'b0;
        set_req(0, 0, 0, 0, 0, 32'h0);
        bus2.req_valid = 1'b0; bus2.out_ready = 1'b0;
        bus2.req_kind = 3'd0; bus2.req_aluop = 4'd0; bus2.req_rd = 5'd3;
        bus2.req_rs1 = 5'd1; bus2.req_rs2 = 5'd2; bus2.req_imm = 32'h0;
        q.delete(); exp_addr = 0; exp_err = 1'b0; exp_cnt = 0;

        // Narrow address counter: wrap after 4 words, then reset mid-stream.
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst2_n = 1'b1;
        bus2.out_ready = 1'b1;
        bus2.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("w2_valid", 32'(bus2.out_valid), 32'd1);
            chk("w2_addr", 32'(bus2.out_addr), 32'(i % 4));
        end
        rst2_n = 1'b0;
        @(posedge clk); #1;
        chk("w2_rst_valid", 32'(bus2.out_valid), 32'd0);
        chk("w2_rst_addr", 32'(bus2.out_addr), 32'd0);
        bus2.req_valid = 1'b0;

        // Reset state of the main DUT.
        cycle();
        cycle();
        rst_n = 1'b1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_instr", bus.out_instr, 32'h0);
        chk("rst_addr", 32'(bus.out_addr), 32'd0);

        // ADD x3, x1, x2
        set_req(0, 0, 3, 1, 2, 32'h0); bus.req_valid = 1'b1;
        cycle();
        bus.req_valid = 1'b0;
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_word", bus.out_instr, 32'h002081B3);
        chk("add_addr", 32'(bus.out_addr), 32'd0);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;

        // Restart addresses, then ADDI x5,x0,-1 and SW x5,8(x2).
        clear = 1'b1; cycle(); clear = 1'b0;
        chk("clr_addr", 32'(bus.out_addr), 32'd0);
        set_req(1, 0, 5, 0, 0, 32'hFFFF_FFFF); bus.req_valid = 1'b1;
        cycle();
        set_req(3, 0, 0, 2, 5, 32'd8);
        cycle();
        bus.req_valid = 1'b0;
        chk("addi_word", bus.out_instr, 32'hFFF00293);
        chk("addi_addr", 32'(bus.out_addr), 32'd0);
        bus.out_ready = 1'b1;
        cycle();
        chk("sw_word", bus.out_instr, 32'h00512423);
        chk("sw_addr", 32'(bus.out_addr), 32'd1);
        cycle();

        // BNE x1,x2,-4 then JAL x1,16 with the consumer always ready.
        set_req(4, 1, 0, 1, 2, 32'hFFFF_FFFC); bus.req_valid = 1'b1;
        cycle();
        chk("bne_word", bus.out_instr, 32'hFE209EE3);
        set_req(5, 0, 1, 0, 0, 32'd16);
        cycle();
        bus.req_valid = 1'b0;
        chk("jal_word", bus.out_instr, 32'h010000EF);
        cycle();
        bus.out_ready = 1'b0;

        // Back-pressure: fill the FIFO, hold the third request, then drain.
        set_req(0, 0, 3, 1, 2, 32'h0); bus.req_valid = 1'b1;
        cycle();
        set_req(0, 1, 4, 5, 6, 32'h0);
        cycle();
        chk("full_ready", 32'(bus.req_ready), 32'd0);
        set_req(0, 4, 7, 8, 9, 32'h0);
        cycle();
        cycle();
        chk("full_hold", bus.out_instr, 32'h002081B3);
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        bus.req_valid = 1'b0;
        cycle();
        cycle();
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // Illegal requests: kind 7, then R-ALU aluop 0111.
        clear = 1'b1; cycle(); clear = 1'b0;
        set_req(7, 0, 1, 1, 1, 32'h0); bus.req_valid = 1'b1;
        cycle();
        set_req(0, 7, 1, 1, 1, 32'h0);
        cycle();
        bus.req_valid = 1'b0;
        chk("ill_valid", 32'(bus.out_valid), 32'd0);
        chk("ill_flag", 32'(err_illegal), 32'd1);
        chk("ill_count", 32'(err_count), 32'd2);
        clear = 1'b1; cycle(); clear = 1'b0;
        chk("ill_clr_count", 32'(err_count), 32'd0);
        chk("ill_clr_addr", 32'(bus.out_addr), 32'd0);

        // Request coinciding with clear is dropped silently.
        set_req(0, 0, 1, 2, 3, 32'h0); bus.req_valid = 1'b1; clear = 1'b1;
        cycle();
        clear = 1'b0; bus.req_valid = 1'b0;
        chk("clr_drop", 32'(bus.out_valid), 32'd0);

        // Saturate the drop counter.
        set_req(6, 0, 0, 0, 0, 32'h0); bus.req_valid = 1'b1;
        for (int i = 0; i < 260; i++) cycle();
        bus.req_valid = 1'b0;
        chk("err_sat", 32'(err_count), 32'd255);
        clear = 1'b1; cycle(); clear = 1'b0;

        // Random traffic, including illegal kinds, back-pressure, clear and reset.
        for (int i = 0; i < 600; i++) begin
            clear = ($urandom_range(0, 59) == 0);
            rst_n = ($urandom_range(0, 149) != 0);
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            set_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), $urandom);
            cycle();
        end
        rst_n = 1'b1; clear = 1'b0; bus.req_valid = 1'b0; bus.out_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
